// File: rtl/sound_cmd_ctrl.sv
// Sound command latch between the 68K and Z80, with Z80 NMI pulse
// generation and uPD7759 port/START/RESET control.
module sound_cmd_ctrl #(
    parameter int NMI_LEN   = 16,
    parameter int NMI_GAP   = 8,
    parameter int START_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m68k_wr,
    input  logic [7:0] m68k_din,
    input  logic       z80_latch_rd,
    input  logic       z80_upd_wr,
    input  logic       z80_upd_rst_wr,
    input  logic [7:0] z80_din,
    output logic [7:0] z80_latch_dout,
    output logic       z80_nmi_n,
    output logic [7:0] upd_port,
    output logic       upd_start,
    output logic       upd_reset_n,
    output logic       cmd_pending,
    output logic       overrun
);

    localparam int MAX_A = (NMI_LEN > NMI_GAP) ? NMI_LEN : NMI_GAP;
    localparam int MAX_C = (MAX_A > START_LEN) ? MAX_A : START_LEN;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] NMI_END   = CW'(NMI_LEN - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(NMI_GAP - 1);
    localparam logic [CW-1:0] START_END = CW'(START_LEN - 1);

    typedef enum logic [1:0] {N_IDLE, N_ASSERT, N_GAP} nmi_state_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PULSE} st_state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    logic wr_q, rd_q, upd_q, rst_q;
    logic wr_edge, rd_edge, upd_edge, rst_edge;

    // Previous-value registers reset high so a strobe held across reset
    // release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= 1'b1;
            rd_q  <= 1'b1;
            upd_q <= 1'b1;
            rst_q <= 1'b1;
        end else begin
            wr_q  <= m68k_wr;
            rd_q  <= z80_latch_rd;
            upd_q <= z80_upd_wr;
            rst_q <= z80_upd_rst_wr;
        end
    end

    assign wr_edge  = m68k_wr & ~wr_q;
    assign rd_edge  = z80_latch_rd & ~rd_q;
    assign upd_edge = z80_upd_wr & ~upd_q;
    assign rst_edge = z80_upd_rst_wr & ~rst_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            z80_latch_dout <= 8'h00;
            cmd_pending    <= 1'b0;
            overrun        <= 1'b0;
            upd_port       <= 8'h00;
            upd_reset_n    <= 1'b0;
        end else begin
            if (wr_edge)
                z80_latch_dout <= m68k_din;
            if (wr_edge)
                cmd_pending <= 1'b1;
            else if (rd_edge)
                cmd_pending <= 1'b0;
            if (wr_edge && cmd_pending && !rd_edge)
                overrun <= 1'b1;
            if (upd_edge)
                upd_port <= z80_din;
            if (rst_edge)
                upd_reset_n <= z80_din[7];
        end
    end

    nmi_state_t    nmi_state, nmi_next;
    logic [CW-1:0] nmi_cnt, nmi_cnt_next;
    logic          queued;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nmi_state <= N_IDLE;
            nmi_cnt   <= '0;
            queued    <= 1'b0;
        end else begin
            nmi_state <= nmi_next;
            nmi_cnt   <= nmi_cnt_next;
            queued    <= (nmi_state == N_IDLE) ? 1'b0 : (queued | wr_edge);
        end
    end

    always_comb begin
        nmi_next     = nmi_state;
        nmi_cnt_next = sat_inc(nmi_cnt);
        unique case (nmi_state)
            N_IDLE: begin
                nmi_cnt_next = '0;
                if (wr_edge || queued)
                    nmi_next = N_ASSERT;
            end
            N_ASSERT: begin
                if (nmi_cnt >= NMI_END) begin
                    nmi_next     = N_GAP;
                    nmi_cnt_next = '0;
                end
            end
            N_GAP: begin
                if (nmi_cnt >= GAP_END) begin
                    nmi_next     = N_IDLE;
                    nmi_cnt_next = '0;
                end
            end
            default: begin
                nmi_next     = N_IDLE;
                nmi_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        z80_nmi_n = (nmi_state != N_ASSERT);
    end

    st_state_t     st_state, st_next;
    logic [CW-1:0] st_cnt, st_cnt_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_state <= S_IDLE;
            st_cnt   <= '0;
        end else begin
            st_state <= st_next;
            st_cnt   <= st_cnt_next;
        end
    end

    // A new write during the pulse keeps START low and restarts its count.
    always_comb begin
        st_next     = st_state;
        st_cnt_next = sat_inc(st_cnt);
        unique case (st_state)
            S_IDLE: begin
                st_cnt_next = '0;
                if (upd_edge)
                    st_next = S_LOAD;
            end
            S_LOAD: begin
                st_cnt_next = '0;
                if (!upd_edge)
                    st_next = S_PULSE;
            end
            S_PULSE: begin
                if (upd_edge) begin
                    st_cnt_next = '0;
                end else if (st_cnt >= START_END) begin
                    st_next     = S_IDLE;
                    st_cnt_next = '0;
                end
            end
            default: begin
                st_next     = S_IDLE;
                st_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        upd_start = (st_state != S_PULSE);
    end

endmodule

// File: tb/tb_sound_cmd_ctrl.sv
// Directed bench for sound_cmd_ctrl; pulse monitors pop expected
// NMI and START pulses from scoreboard queues.
module tb_sound_cmd_ctrl;

    localparam int NMI_LEN   = 16;
    localparam int NMI_GAP   = 8;
    localparam int START_LEN = 4;

    typedef struct {
        logic [7:0] port;
        int         len;
    } upd_exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m68k_wr = 1'b0;
    logic [7:0] m68k_din = 8'h00;
    logic       z80_latch_rd = 1'b0;
    logic       z80_upd_wr = 1'b0;
    logic       z80_upd_rst_wr = 1'b0;
    logic [7:0] z80_din = 8'h00;
    logic [7:0] z80_latch_dout;
    logic       z80_nmi_n;
    logic [7:0] upd_port;
    logic       upd_start;
    logic       upd_reset_n;
    logic       cmd_pending;
    logic       overrun;

    int       errors = 0;
    int       checks = 0;
    int       nmi_q[$];
    upd_exp_t upd_q[$];

    sound_cmd_ctrl #(
        .NMI_LEN(NMI_LEN),
        .NMI_GAP(NMI_GAP),
        .START_LEN(START_LEN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m68k_wr(m68k_wr),
        .m68k_din(m68k_din),
        .z80_latch_rd(z80_latch_rd),
        .z80_upd_wr(z80_upd_wr),
        .z80_upd_rst_wr(z80_upd_rst_wr),
        .z80_din(z80_din),
        .z80_latch_dout(z80_latch_dout),
        .z80_nmi_n(z80_nmi_n),
        .upd_port(upd_port),
        .upd_start(upd_start),
        .upd_reset_n(upd_reset_n),
        .cmd_pending(cmd_pending),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_dout"}, 32'(z80_latch_dout), 32'h00);
        chk({p, "_nmi_n"}, 32'(z80_nmi_n), 32'h1);
        chk({p, "_port"}, 32'(upd_port), 32'h00);
        chk({p, "_start"}, 32'(upd_start), 32'h1);
        chk({p, "_upd_reset_n"}, 32'(upd_reset_n), 32'h0);
        chk({p, "_pending"}, 32'(cmd_pending), 32'h0);
        chk({p, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // NMI pulse monitor: length from scoreboard, minimum high gap
    initial begin
        int  low;
        int  high;
        bit  seen;
        low  = 0;
        high = 0;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                low  = 0;
                high = 0;
                seen = 0;
            end else if (!z80_nmi_n) begin
                if (low == 0 && seen)
                    chk("nmi_gap_min", 32'(high >= NMI_GAP), 32'h1);
                low++;
            end else begin
                if (low != 0) begin
                    chk("nmi_pulse_expected", 32'(nmi_q.size() != 0), 32'h1);
                    if (nmi_q.size() != 0)
                        chk("nmi_pulse_len", 32'(low), 32'(nmi_q.pop_front()));
                    seen = 1;
                    high = 0;
                    low  = 0;
                end
                high++;
            end
        end
    end

    // START pulse monitor: length and port value at pulse end
    initial begin
        int         low;
        logic [7:0] port;
        upd_exp_t   e;
        low  = 0;
        port = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                low = 0;
            end else if (!upd_start) begin
                low++;
                port = upd_port;
            end else if (low != 0) begin
                chk("start_pulse_expected", 32'(upd_q.size() != 0), 32'h1);
                if (upd_q.size() != 0) begin
                    e = upd_q.pop_front();
                    chk("start_pulse_len", 32'(low), 32'(e.len));
                    chk("start_pulse_port", 32'(port), 32'(e.port));
                end
                low = 0;
            end
        end
    end

    initial begin
        int lows;
        upd_exp_t e;

        cyc(3);
        chk_reset("por");
        reset_n = 1'b1;
        cyc(2);

        // long 68K write: one command, one 16-cycle NMI
        m68k_wr  = 1'b1;
        m68k_din = 8'h3A;
        nmi_q.push_back(NMI_LEN);
        cyc(5);
        m68k_wr = 1'b0;
        chk("w1_dout", 32'(z80_latch_dout), 32'h3A);
        chk("w1_pending", 32'(cmd_pending), 32'h1);
        chk("w1_nmi_low", 32'(z80_nmi_n), 32'h0);
        chk("w1_overrun", 32'(overrun), 32'h0);
        cyc(30);

        // write coinciding with read while pending: stays pending, no overrun
        m68k_wr      = 1'b1;
        m68k_din     = 8'h4B;
        z80_latch_rd = 1'b1;
        nmi_q.push_back(NMI_LEN);
        cyc(1);
        m68k_wr      = 1'b0;
        z80_latch_rd = 1'b0;
        chk("coin_pending", 32'(cmd_pending), 32'h1);
        chk("coin_dout", 32'(z80_latch_dout), 32'h4B);
        chk("coin_overrun", 32'(overrun), 32'h0);
        cyc(1);
        z80_latch_rd = 1'b1;
        cyc(1);
        z80_latch_rd = 1'b0;
        chk("rd_pending", 32'(cmd_pending), 32'h0);
        chk("rd_dout_kept", 32'(z80_latch_dout), 32'h4B);
        cyc(30);

        // two writes 3 cycles apart: overrun, two separated NMIs
        m68k_wr  = 1'b1;
        m68k_din = 8'h11;
        nmi_q.push_back(NMI_LEN);
        cyc(1);
        m68k_wr = 1'b0;
        cyc(2);
        m68k_wr  = 1'b1;
        m68k_din = 8'h22;
        nmi_q.push_back(NMI_LEN);
        cyc(1);
        m68k_wr = 1'b0;
        chk("ovr_dout", 32'(z80_latch_dout), 32'h22);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_pending", 32'(cmd_pending), 32'h1);
        cyc(60);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        chk("nmi_queue_drained", 32'(nmi_q.size()), 32'h0);

        // uPD7759 write: port next cycle, then START low 4 cycles
        z80_upd_wr = 1'b1;
        z80_din    = 8'h5C;
        e.port = 8'h5C;
        e.len  = START_LEN;
        upd_q.push_back(e);
        cyc(1);
        chk("upd_port_load", 32'(upd_port), 32'h5C);
        chk("upd_start_high_on_load", 32'(upd_start), 32'h1);
        cyc(1);
        chk("upd_start_low", 32'(upd_start), 32'h0);
        cyc(1);
        z80_upd_wr = 1'b0;
        cyc(10);

        // rewrite two cycles into the pulse restarts the count
        z80_upd_wr = 1'b1;
        z80_din    = 8'h21;
        cyc(1);
        z80_upd_wr = 1'b0;
        cyc(2);
        z80_upd_wr = 1'b1;
        z80_din    = 8'h33;
        e.port = 8'h33;
        e.len  = 2 + START_LEN;
        upd_q.push_back(e);
        cyc(1);
        z80_upd_wr = 1'b0;
        chk("upd_port_reload", 32'(upd_port), 32'h33);
        cyc(12);
        chk("upd_queue_drained", 32'(upd_q.size()), 32'h0);

        // uPD reset line from bit 7
        z80_upd_rst_wr = 1'b1;
        z80_din        = 8'h80;
        cyc(1);
        z80_upd_rst_wr = 1'b0;
        chk("upd_rst_hi", 32'(upd_reset_n), 32'h1);
        cyc(1);
        z80_upd_rst_wr = 1'b1;
        z80_din        = 8'h00;
        cyc(1);
        z80_upd_rst_wr = 1'b0;
        chk("upd_rst_lo", 32'(upd_reset_n), 32'h0);
        cyc(1);
        z80_upd_rst_wr = 1'b1;
        z80_din        = 8'h80;
        cyc(1);
        z80_upd_rst_wr = 1'b0;
        cyc(1);

        // reset mid-NMI with m68k_wr held high across release
        m68k_wr  = 1'b1;
        m68k_din = 8'h77;
        cyc(4);
        chk("pre_rst_nmi_low", 32'(z80_nmi_n), 32'h0);
        reset_n = 1'b0;
        cyc(1);
        chk_reset("mid");
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        m68k_wr = 1'b0;
        chk("post_rst_pending", 32'(cmd_pending), 32'h0);
        chk("post_rst_dout", 32'(z80_latch_dout), 32'h00);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (!z80_nmi_n)
                lows++;
        end
        chk("post_rst_no_nmi", 32'(lows), 32'h0);
        chk("final_nmi_queue", 32'(nmi_q.size()), 32'h0);
        chk("final_upd_queue", 32'(upd_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sound_cmd_ctrl.md
SOUND_CMD_CTRL -- requirements
Module: sound_cmd_ctrl

Interface
REQ-001 SHALL have parameter NMI_LEN, default 16: clk cycles z80_nmi_n is held low per command.
REQ-002 SHALL have parameter NMI_GAP, default 8: minimum clk cycles z80_nmi_n stays high between NMI pulses.
REQ-003 SHALL have parameter START_LEN, default 4: clk cycles upd_start is held low per uPD7759 write.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock; every register in the block uses it
- reset_n  in  1  synchronous reset, active low
- m68k_wr  in  1  68K sound-latch chip select qualified with write strobe; may stay high for many cycles
- m68k_din  in  8  68K data bus low byte
- z80_latch_rd  in  1  Z80 latch chip select (0xF800) qualified with read strobe
- z80_upd_wr  in  1  Z80 I/O write to port 0x40
- z80_upd_rst_wr  in  1  Z80 I/O write to port 0x80
- z80_din  in  8  Z80 data out bus
- z80_latch_dout  out  8  sound command returned to the Z80
- z80_nmi_n  out  1  Z80 NMI, active low
- upd_port  out  8  uPD7759 port data
- upd_start  out  1  uPD7759 START, active low pulse
- upd_reset_n  out  1  uPD7759 RESET, active low
- cmd_pending  out  1  command written and not yet read by the Z80
- overrun  out  1  sticky flag: command overwritten while still pending

Function
REQ-005 SHALL register each strobe input once and detect its rising edge; every action below triggers on the edge, exactly once per access regardless of strobe length.
REQ-006 SHALL, on an m68k_wr edge, load m68k_din into the command register, visible on z80_latch_dout the following cycle, and set cmd_pending.
REQ-007 SHALL, on an m68k_wr edge while cmd_pending=1, overwrite the command and set overrun; overrun clears only on reset.
REQ-008 SHALL, on a z80_latch_rd edge, clear cmd_pending; z80_latch_dout keeps its value.
REQ-009 SHALL, when m68k_wr and z80_latch_rd edges coincide, load the new command and leave cmd_pending=1, with overrun unchanged.
REQ-010 SHALL run the NMI FSM with states IDLE, ASSERT and GAP, driving z80_nmi_n=0 only in ASSERT.
REQ-011 SHALL move the NMI FSM IDLE->ASSERT on the cycle after an m68k_wr edge, or on the cycle after entering IDLE when a request is queued.
REQ-012 SHALL move the NMI FSM ASSERT->GAP after exactly NMI_LEN cycles.
REQ-013 SHALL move the NMI FSM GAP->IDLE after exactly NMI_GAP cycles.
REQ-014 SHALL, on an m68k_wr edge during ASSERT or GAP, set a one-deep queued-request flag; further writes add no extra pulses, and the flag clears when ASSERT is entered.
REQ-015 SHALL, on a z80_upd_wr edge, load z80_din into upd_port on the next cycle, then drive upd_start low for START_LEN cycles, then high.
REQ-016 SHALL, on a z80_upd_wr edge while the start pulse is active, reload upd_port and restart the START_LEN count.
REQ-017 SHALL, on a z80_upd_rst_wr edge, load upd_reset_n from z80_din[7] on the next cycle.
REQ-018 SHALL use counters wide enough for max(NMI_LEN, NMI_GAP, START_LEN), saturating, with no wrap-around.

Reset
REQ-019 SHALL, while reset_n=0 at a clk edge, return all state to reset values: FSMs to IDLE, queued flag cleared, edge detectors cleared, z80_latch_dout=0x00, z80_nmi_n=1, upd_port=0x00, upd_start=1, upd_reset_n=0, cmd_pending=0, overrun=0.
REQ-020 SHALL, when reset is asserted during an NMI or start pulse, terminate the pulse on the reset cycle and emit no residual pulse after release.
REQ-021 SHALL treat a strobe input that is already high when reset_n rises as not an edge.

Verification
REQ-022 SHALL be tested with m68k_wr high for 5 cycles, din=0x3A -> z80_latch_dout=0x3A, cmd_pending=1, and exactly one z80_nmi_n low pulse of 16 cycles.
REQ-023 SHALL be tested with writes 0x11 then 0x22, 3 cycles apart, before any read -> dout=0x22, overrun=1, and two NMI pulses separated by at least 8 high cycles.
REQ-024 SHALL be tested with z80_latch_rd after a write -> cmd_pending=0; an m68k_wr and z80_latch_rd edge in the same cycle -> cmd_pending=1.
REQ-025 SHALL be tested with z80_upd_wr din=0x5C -> upd_port=0x5C, then upd_start low for exactly 4 cycles; z80_upd_rst_wr din=0x80 -> upd_reset_n=1, and din=0x00 -> upd_reset_n=0.
REQ-026 SHALL be tested with reset_n=0 mid NMI pulse while m68k_wr is held high across release -> z80_nmi_n=1, all outputs at reset values, and no pulse after release.
